mem_bus_arbiter: RTL and testbench
==================================

// Module: mem_bus_arbiter
// PURPOSE
//  Shares the single-port main-memory bus between Icache line refills and Dcache line refills/writebacks.
//  Sits below both caches, which are fed by the IF and MEM stages.
//  Round-robin arbitration; every grant owns the bus for one LINE_WORDS-beat burst.
// PARAMETERS
//  LINE_WORDS  4   beats per burst (power of two, >=2); one beat = one 32-bit word
// PORTS
//  clk          in   1   clock
//  rst_n        in   1   asynchronous active-low reset
//  ic_req_i     in   1   Icache refill request; held until ic_gnt_o
//  ic_addr_i    in   32  Icache miss address
//  ic_gnt_o     out  1   1-cycle pulse: Icache burst started
//  ic_rdata_o   out  32  refill word
//  ic_rvalid_o  out  1   ic_rdata_o valid this cycle
//  ic_done_o    out  1   1-cycle pulse on last Icache beat
//  dc_req_i     in   1   Dcache request; held until dc_gnt_o
//  dc_we_i      in   1   1 = writeback burst, 0 = refill burst
//  dc_addr_i    in   32  Dcache line address
//  dc_wdata_i   in   32  writeback word for the current beat
//  dc_gnt_o     out  1   1-cycle pulse: Dcache burst started
//  dc_rdata_o   out  32  refill word
//  dc_rvalid_o  out  1   dc_rdata_o valid (refill)
//  dc_wnext_o   out  1   current write beat accepted; present next word
//  dc_done_o    out  1   1-cycle pulse on last Dcache beat
//  mem_req_o    out  1   bus request; high for every beat of a burst
//  mem_we_o     out  1   write burst
//  mem_addr_o   out  32  beat address
//  mem_wdata_o  out  32  write data (= dc_wdata_i)
//  mem_ack_i    in   1   beat complete; may stall any number of cycles
//  mem_rdata_i  in   32  read data, valid with mem_ack_i
// BEHAVIOUR
//  Reset: state IDLE, beat counter 0, last_owner=DC. All registered outputs 0, mem_addr_o 0.
//  FSM: IDLE, IC_BURST, DC_BURST.
//  IDLE
//   - only ic_req_i -> IC_BURST; only dc_req_i -> DC_BURST.
//   - both -> the requester that is not last_owner.
//   - on entry, latch base = addr & ~(LINE_WORDS*4-1), latch we (DC only), counter 0, update last_owner.
//   - gnt_o pulses in the first burst cycle (registered).
//  Burst
//   - mem_req_o=1; mem_addr_o = base + 4*cnt (32-bit wrap).
//   - each mem_ack_i increments cnt.
//   - beat outputs (combinational with mem_ack_i, owner only):
//     - read: rvalid_o=1, rdata_o=mem_rdata_i.
//     - write: dc_wnext_o=1.
//   - on the ack with cnt==LINE_WORDS-1: done_o=1 in that cycle; next cycle IDLE with mem_req_o=0.
//  Minimum one IDLE cycle between bursts; back-to-back contending requests strictly alternate.
//  Request changes during a burst are ignored; the next arbitration samples req in IDLE.
//  A req dropped before its grant is forgotten.
//  Non-owner rvalid/wnext/done/gnt stay 0. rdata_o outputs may mirror mem_rdata_i at any time.
//  Async reset mid-burst aborts immediately. The next burst restarts from beat 0.
// TESTING
//  1. IC req 0x1008 alone, ack every cycle -> gnt next cycle; addrs 0x1000,04,08,0C; 4 rvalid; done on 4th; IDLE after.
//  2. DC write 0x2010, ack stalls 3 cycles/beat -> mem_addr/wdata held while stalled; wnext x4; done on beat 4.
//  3. IC+DC request same cycle after reset -> IC first. Both re-request at done -> DC next; grants alternate.
//  4. mem_addr_o 0xFFFFFFF0 burst -> addrs FFFFFFF0..FFFFFFFC, no carry beyond bit 31; no spurious DC pulses.
//  5. rst_n low at beat 2 of IC burst -> outputs 0 at once; after release, new DC req bursts from beat 0.
//  6. DC req dropped while IC burst active -> no DC grant; IC dropping req mid-burst still completes 4 beats.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter sharing the single-port main-memory bus between
// Icache refills and Dcache refills/writebacks. Each grant owns the bus
// for one LINE_WORDS-beat burst; at least one idle cycle separates bursts.
//
// state    | meaning
// IDLE     | bus free, arbitrate on the sampled requests
// IC_BURST | Icache refill burst in progress
// DC_BURST | Dcache refill or writeback burst in progress
module mem_bus_arbiter #(
  parameter int LINE_WORDS = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ic_req_i,
  input  logic [31:0] ic_addr_i,
  output logic        ic_gnt_o,
  output logic [31:0] ic_rdata_o,
  output logic        ic_rvalid_o,
  output logic        ic_done_o,
  input  logic        dc_req_i,
  input  logic        dc_we_i,
  input  logic [31:0] dc_addr_i,
  input  logic [31:0] dc_wdata_i,
  output logic        dc_gnt_o,
  output logic [31:0] dc_rdata_o,
  output logic        dc_rvalid_o,
  output logic        dc_wnext_o,
  output logic        dc_done_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_rdata_i
);

  localparam int          CW        = $clog2(LINE_WORDS);
  localparam logic [31:0] LINE_MASK = ~(32'(LINE_WORDS * 4) - 32'd1);
  localparam logic [CW-1:0] LAST_BEAT = CW'(LINE_WORDS - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    IC_BURST = 2'd1,
    DC_BURST = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   base_q, base_d;
  logic          we_q, we_d;
  logic          last_dc_q, last_dc_d;
  logic          ic_gnt_q, ic_gnt_d;
  logic          dc_gnt_q, dc_gnt_d;

  logic pick_ic;
  logic pick_dc;
  logic last_beat;

  // Ties go to whoever did not own the bus last.
  assign pick_ic   = ic_req_i && (!dc_req_i || last_dc_q);
  assign pick_dc   = dc_req_i && (!ic_req_i || !last_dc_q);
  assign last_beat = (cnt_q == LAST_BEAT);

  // State and burst context registers; reset aborts any burst at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      base_q    <= '0;
      we_q      <= 1'b0;
      last_dc_q <= 1'b1;
      ic_gnt_q  <= 1'b0;
      dc_gnt_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      base_q    <= base_d;
      we_q      <= we_d;
      last_dc_q <= last_dc_d;
      ic_gnt_q  <= ic_gnt_d;
      dc_gnt_q  <= dc_gnt_d;
    end
  end

  // Next-state: arbitration in IDLE, beat counting during a burst.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    base_d    = base_q;
    we_d      = we_q;
    last_dc_d = last_dc_q;
    ic_gnt_d  = 1'b0;
    dc_gnt_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_ic) begin
          state_d   = IC_BURST;
          base_d    = ic_addr_i & LINE_MASK;
          we_d      = 1'b0;
          cnt_d     = '0;
          last_dc_d = 1'b0;
          ic_gnt_d  = 1'b1;
        end else if (pick_dc) begin
          state_d   = DC_BURST;
          base_d    = dc_addr_i & LINE_MASK;
          we_d      = dc_we_i;
          cnt_d     = '0;
          last_dc_d = 1'b1;
          dc_gnt_d  = 1'b1;
        end
      end
      IC_BURST, DC_BURST: begin
        if (mem_ack_i) begin
          if (last_beat) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs: bus drive from the burst context, beat strobes follow mem_ack_i.
  always_comb begin
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    ic_rvalid_o = 1'b0;
    ic_done_o   = 1'b0;
    dc_rvalid_o = 1'b0;
    dc_wnext_o  = 1'b0;
    dc_done_o   = 1'b0;
    case (state_q)
      IC_BURST: begin
        mem_req_o   = 1'b1;
        mem_addr_o  = base_q + (32'(cnt_q) << 2);
        ic_rvalid_o = mem_ack_i;
        ic_done_o   = mem_ack_i && last_beat;
      end
      DC_BURST: begin
        mem_req_o   = 1'b1;
        mem_we_o    = we_q;
        mem_addr_o  = base_q + (32'(cnt_q) << 2);
        dc_rvalid_o = mem_ack_i && !we_q;
        dc_wnext_o  = mem_ack_i && we_q;
        dc_done_o   = mem_ack_i && last_beat;
      end
      default: begin
        mem_req_o = 1'b0;
      end
    endcase
  end

  assign ic_gnt_o    = ic_gnt_q;
  assign dc_gnt_o    = dc_gnt_q;
  assign ic_rdata_o  = mem_rdata_i;
  assign dc_rdata_o  = mem_rdata_i;
  assign mem_wdata_o = dc_wdata_i;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: table of single bursts, hand sequences for
// alternation / reset / dropped requests, then random traffic, all watched
// by a transaction-level reference model compared every cycle.
module tb_mem_bus_arbiter;
  localparam int LW = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ic_req_i, dc_req_i, dc_we_i, mem_ack_i;
  logic [31:0] ic_addr_i, dc_addr_i, dc_wdata_i, mem_rdata_i;
  logic        ic_gnt_o, ic_rvalid_o, ic_done_o;
  logic        dc_gnt_o, dc_rvalid_o, dc_wnext_o, dc_done_o;
  logic        mem_req_o, mem_we_o;
  logic [31:0] ic_rdata_o, dc_rdata_o, mem_addr_o, mem_wdata_o;

  int n_checks = 0;
  int n_err    = 0;
  bit mon_en   = 1'b0;

  mem_bus_arbiter #(.LINE_WORDS(LW)) dut (
    .clk(clk), .rst_n(rst_n),
    .ic_req_i(ic_req_i), .ic_addr_i(ic_addr_i), .ic_gnt_o(ic_gnt_o),
    .ic_rdata_o(ic_rdata_o), .ic_rvalid_o(ic_rvalid_o), .ic_done_o(ic_done_o),
    .dc_req_i(dc_req_i), .dc_we_i(dc_we_i), .dc_addr_i(dc_addr_i),
    .dc_wdata_i(dc_wdata_i), .dc_gnt_o(dc_gnt_o), .dc_rdata_o(dc_rdata_o),
    .dc_rvalid_o(dc_rvalid_o), .dc_wnext_o(dc_wnext_o), .dc_done_o(dc_done_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (owner: 0 none, 1 IC, 2 DC) ----------
  int          m_own = 0, m_beat = 0, m_last = 2, m_win;
  logic [31:0] m_base = '0;
  bit          m_we = 1'b0, m_first = 1'b0;

  always_comb begin
    m_win = 0;
    if (ic_req_i && dc_req_i) m_win = (m_last == 1) ? 2 : 1;
    else if (ic_req_i)        m_win = 1;
    else if (dc_req_i)        m_win = 2;
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_own <= 0; m_beat <= 0; m_base <= '0; m_we <= 1'b0; m_first <= 1'b0; m_last <= 2;
    end else if (m_own == 0) begin
      m_first <= 1'b0;
      if (m_win != 0) begin
        m_own   <= m_win;
        m_last  <= m_win;
        m_base  <= (m_win == 1) ? ic_addr_i - (ic_addr_i % (LW * 4))
                                : dc_addr_i - (dc_addr_i % (LW * 4));
        m_we    <= (m_win == 2) && dc_we_i;
        m_beat  <= 0;
        m_first <= 1'b1;
      end
    end else begin
      m_first <= 1'b0;
      if (mem_ack_i) begin
        if (m_beat == LW - 1) m_own <= 0;
        else                  m_beat <= m_beat + 1;
      end
    end
  end

  logic [8:0]  e_flags, a_flags;
  logic [31:0] e_addr;
  always_comb begin
    e_flags[8] = (m_own == 1) && m_first;
    e_flags[7] = (m_own == 1) && mem_ack_i;
    e_flags[6] = (m_own == 1) && mem_ack_i && (m_beat == LW - 1);
    e_flags[5] = (m_own == 2) && m_first;
    e_flags[4] = (m_own == 2) && mem_ack_i && !m_we;
    e_flags[3] = (m_own == 2) && mem_ack_i && m_we;
    e_flags[2] = (m_own == 2) && mem_ack_i && (m_beat == LW - 1);
    e_flags[1] = (m_own != 0);
    e_flags[0] = (m_own == 2) && m_we;
    e_addr     = (m_own != 0) ? m_base + 32'(4 * m_beat) : 32'h0;
  end
  assign a_flags = {ic_gnt_o, ic_rvalid_o, ic_done_o, dc_gnt_o, dc_rvalid_o,
                    dc_wnext_o, dc_done_o, mem_req_o, mem_we_o};

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("model_flags", 32'(a_flags), 32'(e_flags));
      chk("model_addr", mem_addr_o, e_addr);
      chk("model_wdata", mem_wdata_o, dc_wdata_i);
      if (e_flags[7]) chk("model_ic_rdata", ic_rdata_o, mem_rdata_i);
      if (e_flags[4]) chk("model_dc_rdata", dc_rdata_o, mem_rdata_i);
    end
  end

  // ---------------- directed burst table -----------------------------------
  typedef struct {
    logic        ic_req;
    logic        dc_req;
    logic        dc_we;
    logic [31:0] ic_addr;
    logic [31:0] dc_addr;
    int          stall;
    logic        exp_ic;
    logic [31:0] exp_base;
  } vec_t;
  vec_t vecs[8];

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic run_vec(input vec_t v);
    bit got = 1'b0;
    ic_req_i = v.ic_req; dc_req_i = v.dc_req; dc_we_i = v.dc_we;
    ic_addr_i = v.ic_addr; dc_addr_i = v.dc_addr; mem_ack_i = 1'b0;
    for (int k = 0; k < 6 && !got; k++) begin
      @(negedge clk);
      if (ic_gnt_o || dc_gnt_o) got = 1'b1;
      else step();
    end
    chk("gnt_seen", 32'(got), 32'd1);
    if (!got) begin
      step(); ic_req_i = 1'b0; dc_req_i = 1'b0;
      return;
    end
    chk("gnt_ic", 32'(ic_gnt_o), 32'(v.exp_ic));
    chk("gnt_dc", 32'(dc_gnt_o), 32'(!v.exp_ic));
    chk("first_addr", mem_addr_o, v.exp_base);
    step();
    ic_req_i = 1'b0; dc_req_i = 1'b0;
    for (int i = 0; i < LW; i++) begin
      dc_wdata_i = 32'hA500_0000 + 32'(i);
      repeat (v.stall) begin
        mem_ack_i = 1'b0;
        @(negedge clk);
        chk("stall_addr", mem_addr_o, v.exp_base + 32'(4 * i));
        step();
      end
      mem_ack_i = 1'b1; mem_rdata_i = $urandom;
      @(negedge clk);
      chk("beat_addr", mem_addr_o, v.exp_base + 32'(4 * i));
      chk("beat_done", 32'(v.exp_ic ? ic_done_o : dc_done_o), 32'(i == LW - 1));
      chk("other_done", 32'(v.exp_ic ? dc_done_o : ic_done_o), 32'd0);
      if (v.exp_ic) chk("ic_rvalid", 32'(ic_rvalid_o), 32'd1);
      else          chk("dc_strobe", 32'({dc_rvalid_o, dc_wnext_o}), v.dc_we ? 32'd1 : 32'd2);
      step();
    end
    mem_ack_i = 1'b0;
    @(negedge clk);
    chk("idle_after", 32'(mem_req_o), 32'd0);
    step();
  endtask

  initial begin
    int          gq[$];
    int          cnt_rv, cnt_dg, cnt_dn;
    bit          idle_seen;
    // owner history after reset is DC, so ties go IC, then alternate
    vecs[0] = '{1'b1, 1'b0, 1'b0, 32'h0000_1008, 32'h0,         0, 1'b1, 32'h0000_1000};
    vecs[1] = '{1'b0, 1'b1, 1'b1, 32'h0,         32'h0000_2010, 3, 1'b0, 32'h0000_2010};
    vecs[2] = '{1'b1, 1'b1, 1'b0, 32'h0000_3004, 32'h0000_4000, 1, 1'b1, 32'h0000_3000};
    vecs[3] = '{1'b1, 1'b1, 1'b1, 32'h0000_5000, 32'h0000_6008, 0, 1'b0, 32'h0000_6000};
    vecs[4] = '{1'b1, 1'b0, 1'b0, 32'hFFFF_FFF4, 32'h0,         2, 1'b1, 32'hFFFF_FFF0};
    vecs[5] = '{1'b0, 1'b1, 1'b0, 32'h0,         32'hFFFF_FFFF, 0, 1'b0, 32'hFFFF_FFF0};
    vecs[6] = '{1'b1, 1'b0, 1'b0, 32'h0000_001C, 32'h0,         1, 1'b1, 32'h0000_0010};
    vecs[7] = '{1'b0, 1'b1, 1'b0, 32'h0,         32'h0000_7004, 0, 1'b0, 32'h0000_7000};

    rst_n = 1'b0; ic_req_i = 1'b0; dc_req_i = 1'b0; dc_we_i = 1'b0; mem_ack_i = 1'b0;
    ic_addr_i = '0; dc_addr_i = '0; dc_wdata_i = '0; mem_rdata_i = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("reset_flags", 32'(a_flags), 32'd0);
    chk("reset_addr", mem_addr_o, 32'd0);
    mon_en = 1'b1;
    step();

    // simultaneous requests right after reset, both held: strict alternation
    ic_req_i = 1'b1; dc_req_i = 1'b1; dc_we_i = 1'b0;
    ic_addr_i = 32'h0000_0100; dc_addr_i = 32'h0000_0200; mem_ack_i = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (ic_gnt_o) gq.push_back(1);
      if (dc_gnt_o) gq.push_back(2);
      step();
    end
    ic_req_i = 1'b0; dc_req_i = 1'b0;
    idle_seen = 1'b0;
    for (int c = 0; c < 12 && !idle_seen; c++) begin
      @(negedge clk);
      if (!mem_req_o) idle_seen = 1'b1;
      step();
    end
    chk("alt_drain", 32'(idle_seen), 32'd1);
    mem_ack_i = 1'b0;
    chk("alt_count", 32'(gq.size() >= 6), 32'd1);
    for (int k = 0; k < 6 && k < gq.size(); k++)
      chk("alt_order", 32'(gq[k]), (k % 2 == 0) ? 32'd1 : 32'd2);
    step();

    // restore owner history to DC so the table's tie expectations hold
    run_vec(vecs[7]);
    for (int i = 0; i < 7; i++) run_vec(vecs[i]);

    // reset at beat 2 of an IC burst, then a DC burst from beat 0
    ic_req_i = 1'b1; ic_addr_i = 32'h0000_8000;
    idle_seen = 1'b0;
    for (int k = 0; k < 6 && !idle_seen; k++) begin
      @(negedge clk);
      if (ic_gnt_o) idle_seen = 1'b1;
      else step();
    end
    chk("rst_gnt", 32'(idle_seen), 32'd1);
    step(); ic_req_i = 1'b0; mem_ack_i = 1'b1;
    step(); step();
    rst_n = 1'b0;
    #1;
    chk("rst_flags", 32'(a_flags), 32'd0);
    chk("rst_addr", mem_addr_o, 32'd0);
    mem_ack_i = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    run_vec(vecs[7]);

    // DC request dropped before grant during an IC burst; IC drops mid-burst
    ic_req_i = 1'b1; ic_addr_i = 32'h0000_9000;
    idle_seen = 1'b0;
    for (int k = 0; k < 6 && !idle_seen; k++) begin
      @(negedge clk);
      if (ic_gnt_o) idle_seen = 1'b1;
      else step();
    end
    chk("drop_gnt", 32'(idle_seen), 32'd1);
    cnt_rv = 0; cnt_dg = 0; cnt_dn = 0;
    for (int c = 0; c < 10; c++) begin
      step();
      ic_req_i = 1'b0; mem_ack_i = 1'b1; mem_rdata_i = $urandom;
      dc_req_i = (c < 2); dc_addr_i = 32'h0000_A000; dc_we_i = 1'b0;
      @(negedge clk);
      if (ic_rvalid_o) cnt_rv++;
      if (ic_done_o)   cnt_dn++;
      if (dc_gnt_o || mem_req_o && c >= 4) cnt_dg++;
    end
    chk("drop_ic_beats", 32'(cnt_rv), 32'd4);
    chk("drop_ic_done", 32'(cnt_dn), 32'd1);
    chk("drop_no_dc", 32'(cnt_dg), 32'd0);
    step(); mem_ack_i = 1'b0;

    // random traffic under the model
    for (int c = 0; c < 500; c++) begin
      step();
      if (ic_req_i && ic_gnt_o)      ic_req_i = ($urandom_range(0, 3) == 0);
      else if (!ic_req_i) begin
        if ($urandom_range(0, 3) == 0) begin ic_req_i = 1'b1; ic_addr_i = $urandom; end
      end else if ($urandom_range(0, 19) == 0) ic_req_i = 1'b0;
      if (dc_req_i && dc_gnt_o)      dc_req_i = ($urandom_range(0, 3) == 0);
      else if (!dc_req_i) begin
        if ($urandom_range(0, 3) == 0) begin
          dc_req_i = 1'b1; dc_addr_i = $urandom; dc_we_i = $urandom_range(0, 1) == 1;
        end
      end else if ($urandom_range(0, 19) == 0) dc_req_i = 1'b0;
      mem_ack_i   = ($urandom_range(0, 2) != 0);
      mem_rdata_i = $urandom;
      dc_wdata_i  = $urandom;
    end
    ic_req_i = 1'b0; dc_req_i = 1'b0; mem_ack_i = 1'b1;
    repeat (12) step();
    @(negedge clk);
    chk("final_idle", 32'(mem_req_o), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
